// File: rtl/inst_encoder.sv
// inst_encoder: packs ADD/ADDI/LI requests into RV32I words and streams
// them through a small show-ahead output FIFO.
module inst_encoder #(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        trunc,
  output logic        busy
);
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t        state;
  logic [31:0]   mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [4:0]    pend_rd;
  logic [11:0]   pend_lo;

  logic        has_room;
  logic        accept;
  logic        push;
  logic        pop;
  logic        fits;
  logic [11:0] lo;
  logic [19:0] hi;
  logic [31:0] first_word;
  logic [31:0] push_word;
  logic        two_word;
  logic        is_addi;

  assign has_room = count < DEPTH_C;
  assign req_ready = !rst && (state == IDLE) && has_room;
  assign accept = req_valid && req_ready;
  assign inst_valid = count != '0;
  assign inst = mem[rd_ptr];
  assign pop = inst_valid && inst_ready;
  assign busy = (state != IDLE) || inst_valid;

  assign fits = (&req_imm[31:11]) || !(|req_imm[31:11]);
  assign lo = req_imm[11:0];
  // Rounding up compensates for the sign extension of the low ADDI
  assign hi = req_imm[31:12] + {19'd0, req_imm[11]};
  assign is_addi = req_op == 2'b01;

  always_comb begin
    first_word = NOP;
    two_word = 1'b0;
    unique case (req_op)
      2'b00:
        first_word = {7'd0, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
      2'b01:
        first_word = {lo, req_rs1, 3'b000, req_rd, 7'b0010011};
      2'b10: begin
        if (fits) begin
          first_word = {lo, 5'd0, 3'b000, req_rd, 7'b0010011};
        end else begin
          first_word = {hi, req_rd, 7'b0110111};
          two_word = lo != 12'd0;
        end
      end
      default: first_word = NOP;
    endcase
  end

  assign push = accept || ((state == SECOND) && has_room);
  assign push_word = (state == SECOND)
    ? {pend_lo, pend_rd, 3'b000, pend_rd, 7'b0010011}
    : first_word;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pend_rd <= '0;
      pend_lo <= '0;
      trunc <= 1'b0;
    end else begin
      trunc <= accept && is_addi && !fits;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10: count <= count + CW'(1);
        2'b01: count <= count - CW'(1);
        default: count <= count;
      endcase
      unique case (state)
        IDLE: begin
          if (accept && two_word) begin
            pend_rd <= req_rd;
            pend_lo <= lo;
            state <= SECOND;
          end
        end
        SECOND: begin
          if (has_room) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomized checks of inst_encoder
// against an arithmetic model of the RV32I encodings.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic        trunc;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_encoder #(.OUT_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .trunc(trunc), .busy(busy)
  );

  function automatic logic [31:0] m_addi(int rd, int rs1, longint imm12);
    return 32'((imm12 << 20) + (rs1 << 15) + (rd << 7) + 'h13);
  endfunction

  // Appends the expected words to exp_q; tr reports an ADDI overflow
  function automatic void model(input logic [1:0] op, input int rd,
      input int rs1, input int rs2, input logic [31:0] imm,
      output bit tr);
    int simm;
    bit ok12;
    longint lo;
    longint hi;
    simm = int'(imm);
    ok12 = (simm >= -2048) && (simm <= 2047);
    lo = longint'(imm) % 4096;
    hi = ((longint'(imm) + 2048) % 64'h1_0000_0000) / 4096;
    tr = 0;
    case (op)
      2'd0: exp_q.push_back(32'((rs2 << 20) + (rs1 << 15) + (rd << 7) + 'h33));
      2'd1: begin
        exp_q.push_back(m_addi(rd, rs1, lo));
        tr = !ok12;
      end
      2'd2: begin
        if (ok12) exp_q.push_back(m_addi(rd, 0, lo));
        else begin
          exp_q.push_back(32'((hi << 12) + (rd << 7) + 'h37));
          if (lo != 0) exp_q.push_back(m_addi(rd, rd, lo));
        end
      end
      default: exp_q.push_back(32'h13);
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_op = op; req_rd = rd;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL send_timeout req_ready=%0b want 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 0 || inst_valid !== 0 || busy !== 0 || trunc !== 0) begin
      errors++;
      $display("FAIL reset_state rdy=%b v=%b busy=%b tr=%b want 0000",
        req_ready, inst_valid, busy, trunc);
    end
    rst = 0;
    #1;
    checks++;
    if (req_ready !== 1) begin
      errors++;
      $display("FAIL reset_release req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_add();
    inst_ready = 1;
    send(2'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    checks++;
    if (inst_valid !== 1 || inst !== 32'h002081B3 || busy !== 1) begin
      errors++;
      $display("FAIL add_word v=%b inst=%h busy=%b want 1 002081b3 1",
        inst_valid, inst, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (inst_valid !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL add_once v=%b busy=%b want 0 0", inst_valid, busy);
    end
  endtask

  task automatic test_addi();
    logic [4:0]  rs1s[3] = '{5'd0, 5'd1, 5'd0};
    logic [31:0] imms[3] = '{32'd5, 32'hFFFF_FFFF, 32'h800};
    logic [31:0] want[3] = '{32'h00500093, 32'hFFF08093, 32'h80000093};
    logic        trs[3]  = '{1'b0, 1'b0, 1'b1};
    inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      send(2'd1, 5'd1, rs1s[i], 5'd0, imms[i]);
      checks++;
      if (inst_valid !== 1 || inst !== want[i] || trunc !== trs[i]) begin
        errors++;
        $display("FAIL addi_%0d v=%b inst=%h tr=%b want 1 %h %b",
          i, inst_valid, inst, trunc, want[i], trs[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (trunc !== 0 || inst_valid !== 0) begin
        errors++;
        $display("FAIL addi_after_%0d tr=%b v=%b want 0 0", i, trunc, inst_valid);
      end
    end
  endtask

  task automatic test_li();
    logic [31:0] imms[3] = '{32'h12345FFF, 32'h00010000, 32'hFFFF_FFFD};
    logic [31:0] w0[3] = '{32'h123462B7, 32'h000102B7, 32'hFFD00293};
    logic [31:0] w1[3] = '{32'hFFF28293, 32'h0, 32'h0};
    bit          two[3] = '{1'b1, 1'b0, 1'b0};
    inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      send(2'd2, 5'd5, 5'd0, 5'd0, imms[i]);
      checks++;
      if (inst_valid !== 1 || inst !== w0[i] || req_ready !== !two[i]) begin
        errors++;
        $display("FAIL li_first_%0d v=%b inst=%h rdy=%b want 1 %h %b",
          i, inst_valid, inst, req_ready, w0[i], !two[i]);
      end
      @(posedge clk); #1;
      if (two[i]) begin
        checks++;
        if (inst_valid !== 1 || inst !== w1[i]) begin
          errors++;
          $display("FAIL li_second_%0d v=%b inst=%h want 1 %h",
            i, inst_valid, inst, w1[i]);
        end
        @(posedge clk); #1;
      end
      checks++;
      if (inst_valid !== 0) begin
        errors++;
        $display("FAIL li_end_%0d v=%b want 0", i, inst_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] want[3] = '{32'h002081B3, 32'h00418233, 32'h006283B3};
    logic [31:0] got[$];
    bit fire;
    inst_ready = 0;
    send(2'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(2'd0, 5'd4, 5'd3, 5'd4, 32'd0);
    @(negedge clk);
    req_valid = 1; req_op = 2'd0; req_rd = 5'd7; req_rs1 = 5'd5; req_rs2 = 5'd6;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (req_ready !== 0 || inst_valid !== 1 || inst !== want[0]) begin
        errors++;
        $display("FAIL bp_hold_%0d rdy=%b v=%b inst=%h want 0 1 %h",
          c, req_ready, inst_valid, inst, want[0]);
      end
      @(negedge clk);
    end
    inst_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (inst_valid) got.push_back(inst);
      fire = req_valid && req_ready;
      @(posedge clk);
      #1 if (fire) req_valid = 0;
      @(negedge clk);
    end
    checks++;
    if (got.size() !== 3 || req_valid !== 0) begin
      errors++;
      $display("FAIL bp_count got=%0d words rv=%b want 3 0", got.size(), req_valid);
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL bp_order_%0d got=%h want %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_reserved();
    inst_ready = 1;
    send(2'd3, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    checks++;
    if (inst_valid !== 1 || inst !== 32'h13 || trunc !== 0) begin
      errors++;
      $display("FAIL reserved v=%b inst=%h tr=%b want 1 00000013 0",
        inst_valid, inst, trunc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_second();
    inst_ready = 0;
    send(2'd2, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    rst = 1;
    #1;
    checks++;
    if (req_ready !== 0) begin
      errors++;
      $display("FAIL rst_rdy req_ready=%b want 0", req_ready);
    end
    @(posedge clk);
    #1 rst = 0;
    #1;
    checks++;
    if (inst_valid !== 0 || busy !== 0 || req_ready !== 1) begin
      errors++;
      $display("FAIL rst_flush v=%b busy=%b rdy=%b want 0 0 1",
        inst_valid, busy, req_ready);
    end
    inst_ready = 1;
    send(2'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    checks++;
    if (inst_valid !== 1 || inst !== 32'h002081B3) begin
      errors++;
      $display("FAIL rst_add v=%b inst=%h want 1 002081b3", inst_valid, inst);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (inst_valid !== 0) begin
        errors++;
        $display("FAIL rst_leak v=%b inst=%h want no word", inst_valid, inst);
      end
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc = 0;
    int n;
    bit have = 0;
    bit exp_tr = 0;
    bit exp_blk = 0;
    bit tr;
    logic [31:0] w;
    exp_q.delete();
    while ((sent < 300 || have || exp_q.size() != 0) && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (trunc !== exp_tr) begin
        errors++;
        $display("FAIL rnd_trunc cyc=%0d tr=%b want %b", cyc, trunc, exp_tr);
      end
      if (exp_blk) begin
        checks++;
        if (req_ready !== 0) begin
          errors++;
          $display("FAIL rnd_li_block cyc=%0d rdy=%b want 0", cyc, req_ready);
        end
      end
      if (!have && sent < 300 && $urandom_range(0, 3) != 0) begin
        have = 1;
        req_op = 2'($urandom);
        req_rd = 5'($urandom);
        req_rs1 = 5'($urandom);
        req_rs2 = 5'($urandom);
        case ($urandom_range(0, 4))
          0: req_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          1: req_imm = $urandom & 32'hFFFF_F000;
          2: req_imm = $urandom_range(0, 1) ? 32'h7FF + 32'($urandom_range(0, 2))
                                            : 32'hFFFF_F800 - 32'($urandom_range(0, 2));
          default: req_imm = $urandom;
        endcase
      end
      req_valid = have;
      inst_ready = $urandom_range(0, 2) != 0;
      #1;
      exp_tr = 0;
      exp_blk = 0;
      if (inst_valid && inst_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra inst=%h want no word", inst);
        end else begin
          w = exp_q.pop_front();
          if (inst !== w) begin
            errors++;
            $display("FAIL rnd_word cyc=%0d inst=%h want %h", cyc, inst, w);
          end
        end
      end
      if (req_valid && req_ready) begin
        n = exp_q.size();
        model(req_op, int'(req_rd), int'(req_rs1), int'(req_rs2), req_imm, tr);
        exp_tr = tr;
        exp_blk = (exp_q.size() - n) == 2;
        have = 0;
        sent++;
      end
    end
    req_valid = 0;
    checks++;
    if (cyc >= 8000) begin
      errors++;
      $display("FAIL rnd_timeout sent=%0d left=%0d want 300 0", sent, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_li();
    test_backpressure();
    test_reserved();
    test_reset_second();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder for the 3-stage RV32I core's test and bring-up path, the encoding counterpart of the decode stage. It accepts symbolic requests (ADD, ADDI, load-immediate) over a valid/ready handshake and packs them into 32-bit RV32I instruction words. Load-immediate expands into a LUI/ADDI pair when needed. Words are buffered in a small output FIFO and streamed out under valid/ready, to feed instruction memory or drive the decode stage directly in benches.

## Interface
- OUT_DEPTH, default 2: output FIFO depth in words; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on cycle with req_valid && req_ready.
- req_op  in  2  operation select:
  - 00: ADD.
  - 01: ADDI.
  - 10: LI (load 32-bit immediate).
  - 11: reserved, encoded as NOP.
- req_rd  in  5  destination register.
- req_rs1  in  5  source 1 (ADD, ADDI).
- req_rs2  in  5  source 2 (ADD only).
- req_imm  in  32  immediate (ADDI, LI).
- inst_valid  out  1  FIFO head holds a word.
- inst_ready  in  1  consumer takes head on inst_valid && inst_ready.
- inst  out  32  encoded instruction (FIFO head, show-ahead).
- trunc  out  1  one-cycle pulse: accepted ADDI whose imm does not fit 12-bit signed.
- busy  out  1  FSM not IDLE or FIFO non-empty.

## Operation
- Encodings, with funct3 = 000 throughout:
  - ADD: {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011}.
  - ADDI: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
  - LUI: {hi[19:0], rd, 7'b0110111}.
  - NOP: 0x00000013.
- ADDI fit test: imm[31:11] all equal. If not, encode imm[11:0] anyway and pulse trunc the cycle after acceptance.
- LI, with lo = imm[11:0] and hi = imm[31:12] + imm[11] (20-bit, wraps mod 2^20):
  - imm[31:11] all equal → one word, ADDI rd, x0, lo.
  - else, lo == 0 → one word, LUI rd, hi.
  - else → two words, LUI rd, hi then ADDI rd, rd, lo.
- rd = x0 is encoded as given, with no special-casing.
- FSM states:
  - IDLE: req_ready = (count < OUT_DEPTH). On acceptance, push the first word. For a two-word LI, latch rd and lo and go to SECOND; otherwise stay in IDLE.
  - SECOND: req_ready = 0. When count < OUT_DEPTH, push ADDI rd, rd, lo and go to IDLE; else hold.
- FIFO behaviour:
  - Circular buffer, OUT_DEPTH entries; read/write pointers wrap modulo OUT_DEPTH.
  - count has width clog2(OUT_DEPTH)+1.
  - Push and pop in the same cycle leave count unchanged.
  - Push is never attempted when full: req_ready already accounts for this, and it uses registered count only (no combinational path from inst_ready).
  - Pop only when inst_valid && inst_ready.
- Output order equals request order; words are never reordered or dropped except by reset.

## Timing
- Reset values: state IDLE, count 0, pointers 0, inst_valid 0, trunc 0, busy 0.
- req_ready is 0 while rst is high and 1 on the first cycle after rst deasserts.
- inst is don't-care while inst_valid is 0.
- Latency: request accepted at edge N → word is the FIFO head with inst_valid high from N+1 (if the FIFO was empty).
- Second LI word is pushed at edge N+1 at the earliest.
- inst and inst_valid hold stable while inst_valid && !inst_ready.
- Throughput: one word per cycle. A two-word LI blocks req_ready for ≥1 cycle.
- Full FIFO with a simultaneous pop: req_ready is still 0 that cycle, and the request is accepted next cycle.
- Reset mid-operation (including in SECOND): FIFO is flushed and the pending ADDI is discarded. inst_valid is 0 the cycle after rst, and no partial LI is ever emitted afterwards.
- trunc is asserted for exactly one cycle per offending ADDI and is independent of backpressure.

## Test plan
- ADD rd=3 rs1=1 rs2=2, inst_ready=1 → inst = 0x002081B3 with inst_valid high exactly one cycle after acceptance.
- ADDI cases:
  - rd=1 rs1=0 imm=5 → 0x00500093.
  - rd=1 rs1=1 imm=-1 → 0xFFF08093, trunc 0.
  - rd=1 rs1=0 imm=0x800 → 0x80000093, with a trunc pulse of one cycle.
- LI cases:
  - rd=5 imm=0x12345FFF → 0x123462B7 then 0xFFF28293.
  - rd=5 imm=0x00010000 → single word 0x000102B7.
  - rd=5 imm=-3 → single word 0xFFD00293.
- Backpressure with OUT_DEPTH=2, inst_ready=0, three ADD requests back-to-back:
  - First two are accepted, then req_ready=0 and inst is held stable.
  - After inst_ready=1, all three words emerge in order with no duplicates.
- req_op=11 with arbitrary fields → 0x00000013.
- Reset between the words: LI rd=5 imm=0x12345FFF with inst_ready=0, rst asserted in SECOND → inst_valid=0 and busy=0 after reset. A subsequent ADD request produces only the ADD word.
